// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-setting controller: state encoding,
// digit field maxima and default timing parameters.
package watch_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_H   = 3'd1,
    ST_SET_M10 = 3'd2,
    ST_SET_M1  = 3'd3,
    ST_LOAD    = 3'd4
  } state_t;

  localparam logic [4:0] H_MAX   = 5'd23;
  localparam logic [2:0] M10_MAX = 3'd5;
  localparam logic [3:0] M1_MAX  = 4'd9;

  localparam logic [15:0] DEB_CYC_DEF     = 16'd1000;
  localparam logic [15:0] LOAD_CYC_DEF    = 16'd2000;
  localparam logic [23:0] TIMEOUT_CYC_DEF = 24'd600000;
  localparam logic [15:0] BLINK_DIV_DEF   = 16'd500;

  function automatic logic is_set(input state_t s);
    return (s == ST_SET_H) || (s == ST_SET_M10) || (s == ST_SET_M1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, level debouncer and a
// one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce
  import watch_pkg::*;
#(
  parameter logic [15:0] DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic        level_d;
  logic [15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      // Any sample agreeing with the accepted level restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DEB_CYC - 16'd1) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-setting controller: walks hours / minutes-tens / minutes-units edit
// states, holds the counter chain in load while editing and drives blink masks.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter logic [15:0] DEB_CYC     = DEB_CYC_DEF,
  parameter logic [15:0] LOAD_CYC    = LOAD_CYC_DEF,
  parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [15:0] BLINK_DIV   = BLINK_DIV_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  output logic       cnt_rst_o,
  output logic [4:0] ival_h_o,
  output logic [2:0] ival_m10_o,
  output logic [3:0] ival_m1_o,
  output logic       set_active_o,
  output logic [2:0] blank_o,
  output logic [2:0] state_o
);

  state_t      state;
  state_t      state_nxt;
  logic        mode_press;
  logic        inc_press;
  logic [4:0]  h_nxt;
  logic [2:0]  m10_nxt;
  logic [3:0]  m1_nxt;
  logic [23:0] idle_cnt;
  logic [15:0] load_cnt;
  logic [15:0] blink_cnt;
  logic        phase;
  logic        in_set;
  logic        idle_done;
  logic        load_done;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk   (clk_i),
    .rst   (rst_i),
    .raw   (btn_mode_i),
    .press (mode_press)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
    .clk   (clk_i),
    .rst   (rst_i),
    .raw   (btn_inc_i),
    .press (inc_press)
  );

  assign in_set    = is_set(state);
  assign idle_done = (idle_cnt == TIMEOUT_CYC - 24'd1);
  assign load_done = (load_cnt == LOAD_CYC - 16'd1);
  assign state_o   = state;

  // Mode has priority over inc, so a simultaneous inc is dropped.
  always_comb begin
    state_nxt = state;
    h_nxt     = ival_h_o;
    m10_nxt   = ival_m10_o;
    m1_nxt    = ival_m1_o;
    case (state)
      ST_RUN: begin
        if (mode_press) state_nxt = ST_SET_H;
      end
      ST_SET_H: begin
        if (mode_press)     state_nxt = ST_SET_M10;
        else if (inc_press) h_nxt = (ival_h_o == H_MAX) ? 5'd0 : ival_h_o + 5'd1;
        else if (idle_done) state_nxt = ST_LOAD;
      end
      ST_SET_M10: begin
        if (mode_press)     state_nxt = ST_SET_M1;
        else if (inc_press) m10_nxt = (ival_m10_o == M10_MAX) ? 3'd0 : ival_m10_o + 3'd1;
        else if (idle_done) state_nxt = ST_LOAD;
      end
      ST_SET_M1: begin
        if (mode_press)     state_nxt = ST_LOAD;
        else if (inc_press) m1_nxt = (ival_m1_o == M1_MAX) ? 4'd0 : ival_m1_o + 4'd1;
        else if (idle_done) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (load_done) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_RUN;
      ival_h_o   <= '0;
      ival_m10_o <= '0;
      ival_m1_o  <= '0;
    end else begin
      state      <= state_nxt;
      ival_h_o   <= h_nxt;
      ival_m10_o <= m10_nxt;
      ival_m1_o  <= m1_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt  <= '0;
      load_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (!in_set || state_nxt != state || mode_press || inc_press) idle_cnt <= '0;
      else                                                          idle_cnt <= idle_cnt + 24'd1;

      if (state == ST_LOAD) load_cnt <= load_cnt + 16'd1;
      else                  load_cnt <= '0;

      // Blink runs continuously across the edit states and parks at 0 elsewhere.
      if (!in_set) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (blink_cnt == BLINK_DIV - 16'd1) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_rst_o    <= 1'b0;
      set_active_o <= 1'b0;
      blank_o      <= 3'b000;
    end else begin
      cnt_rst_o    <= (state != ST_RUN);
      set_active_o <= (state != ST_RUN);
      case (state)
        ST_SET_H:   blank_o <= {phase, 2'b00};
        ST_SET_M10: blank_o <= {1'b0, phase, 1'b0};
        ST_SET_M1:  blank_o <= {2'b00, phase};
        default:    blank_o <= 3'b000;
      endcase
    end
  end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Randomised bench for watch_set_ctrl, checked cycle by cycle against a
// behavioural model of the button timing and the set-mode sequencing.
module tb_watch_set_ctrl;
  import watch_pkg::*;

  localparam int DEB   = 4;
  localparam int LOADC = 8;
  localparam int TOUT  = 64;
  localparam int BDIV  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       b_mode = 1'b0;
  logic       b_inc = 1'b0;
  logic       cnt_rst;
  logic [4:0] ival_h;
  logic [2:0] ival_m10;
  logic [3:0] ival_m1;
  logic       set_active;
  logic [2:0] blank;
  logic [2:0] state_dbg;

  watch_set_ctrl #(
    .DEB_CYC     (16'd4),
    .LOAD_CYC    (16'd8),
    .TIMEOUT_CYC (24'd64),
    .BLINK_DIV   (16'd4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .btn_mode_i   (b_mode),
    .btn_inc_i    (b_inc),
    .cnt_rst_o    (cnt_rst),
    .ival_h_o     (ival_h),
    .ival_m10_o   (ival_m10),
    .ival_m1_o    (ival_m1),
    .set_active_o (set_active),
    .blank_o      (blank),
    .state_o      (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [11:0] exp_q[$];

  // Model: 0 RUN, 1 SET_H, 2 SET_M10, 3 SET_M1, 4 LOAD
  int m_st, m_h, m_m10, m_m1, m_phase, m_entry, m_last, m_load;
  int exp_rst, exp_blank;
  logic [7:0] sh_m, sh_i;
  logic deb_m, deb_i, rise_m, rise_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] st_code(input int s);
    case (s)
      1:       return ST_SET_H;
      2:       return ST_SET_M10;
      3:       return ST_SET_M1;
      4:       return ST_LOAD;
      default: return ST_RUN;
    endcase
  endfunction

  // A level is accepted once the last DEB synchronised samples all show it.
  function automatic bit win_eq(input logic [7:0] sh, input logic v);
    for (int k = 2; k < DEB + 2; k++) if (sh[k] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m10 = 0; m_m1 = 0; m_phase = 0;
    m_entry = 0; m_last = 0; m_load = 0;
    exp_rst = 0; exp_blank = 0;
    sh_m = '0; sh_i = '0;
    deb_m = 1'b0; deb_i = 1'b0; rise_m = 1'b0; rise_i = 1'b0;
  endtask

  task automatic model_step(input logic bm, input logic bi);
    logic pm, pi;
    int   new_phase;
    exp_rst   = (m_st != 0) ? 1 : 0;
    exp_blank = (m_st == 1) ? m_phase * 4 : (m_st == 2) ? m_phase * 2 : (m_st == 3) ? m_phase : 0;
    new_phase = (m_st >= 1 && m_st <= 3) ? ((cyc - m_entry) / BDIV) % 2 : 0;
    pm = rise_m;
    pi = rise_i;
    case (m_st)
      0: if (pm) begin m_st = 1; m_entry = cyc; m_last = cyc; end
      1, 2, 3: begin
        if (pm) begin
          m_st = m_st + 1;
          m_last = cyc;
          if (m_st == 4) m_load = cyc;
        end else if (pi) begin
          if (m_st == 1) m_h = (m_h + 1) % 24;
          else if (m_st == 2) m_m10 = (m_m10 + 1) % 6;
          else m_m1 = (m_m1 + 1) % 10;
          m_last = cyc;
        end else if (cyc - m_last == TOUT) begin
          m_st = 4;
          m_load = cyc;
        end
      end
      default: if (cyc - m_load == LOADC) m_st = 0;
    endcase
    m_phase = new_phase;
    sh_m = {sh_m[6:0], bm};
    sh_i = {sh_i[6:0], bi};
    rise_m = 1'b0;
    rise_i = 1'b0;
    if (win_eq(sh_m, ~deb_m)) begin rise_m = ~deb_m; deb_m = ~deb_m; end
    if (win_eq(sh_i, ~deb_i)) begin rise_i = ~deb_i; deb_i = ~deb_i; end
  endtask

  task automatic compare_all();
    check_eq("cnt_rst",    32'(cnt_rst),    exp_rst);
    check_eq("set_active", 32'(set_active), exp_rst);
    check_eq("blank",      32'(blank),      exp_blank);
    check_eq("ival_h",     32'(ival_h),     m_h);
    check_eq("ival_m10",   32'(ival_m10),   m_m10);
    check_eq("ival_m1",    32'(ival_m1),    m_m1);
    check_eq("state",      32'(state_dbg),  32'(st_code(m_st)));
  endtask

  task automatic tick(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else     model_step(b_mode, b_inc);
      #1;
      compare_all();
    end
  endtask

  // kind: 0 inc, 1 mode, 2 both together
  task automatic press(input int kind);
    int hold, gap;
    hold = $urandom_range(DEB, DEB + 3);
    gap  = $urandom_range(DEB + 1, DEB + 4);
    if (kind == 0) b_inc = 1'b1;
    else if (kind == 1) b_mode = 1'b1;
    else begin b_inc = 1'b1; b_mode = 1'b1; end
    tick(hold);
    b_inc = 1'b0;
    b_mode = 1'b0;
    tick(gap);
  endtask

  task automatic glitch(input int len);
    b_inc = 1'b1;
    tick(len);
    b_inc = 1'b0;
    tick(1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_cnt_rst", 32'(cnt_rst), 0);
    check_eq("rst_state",   32'(state_dbg), 32'(ST_RUN));
    check_eq("rst_ival_h",  32'(ival_h), 0);
    check_eq("rst_blank",   32'(blank), 0);
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic check_session();
    logic [11:0] e;
    e = exp_q.pop_front();
    check_eq("sess_h",   32'(ival_h),   32'(e[11:7]));
    check_eq("sess_m10", 32'(ival_m10), 32'(e[6:4]));
    check_eq("sess_m1",  32'(ival_m1),  32'(e[3:0]));
  endtask

  initial begin
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(100);

    // Full edit walk
    press(1);
    repeat (3) press(0);
    press(1);
    repeat (5) press(0);
    press(1);
    repeat (2) press(0);
    press(1);
    tick(20);
    exp_q.push_back({5'd3, 3'd5, 4'd2});
    check_session();

    // Wrap boundaries from a clean start
    pulse_reset();
    press(1);
    repeat (25) press(0);
    press(1);
    repeat (6) press(0);
    press(1);
    repeat (10) press(0);
    press(1);
    tick(20);
    exp_q.push_back({5'd1, 3'd0, 4'd0});
    check_session();

    // Idle timeout out of SET_H
    press(1);
    tick(100);
    check_eq("timeout_state", 32'(state_dbg), 32'(ST_RUN));

    // Glitches and bounce trains must not count
    press(1);
    glitch(2);
    tick(DEB + 3);
    glitch(3); glitch(3); glitch(3);
    tick(DEB + 3);
    check_eq("glitch_h", 32'(ival_h), 1);
    press(0);
    check_eq("clean_h", 32'(ival_h), 2);

    // Simultaneous press in SET_M10, then reset mid SET_M1
    press(1);
    press(2);
    check_eq("both_state", 32'(state_dbg), 32'(ST_SET_M1));
    check_eq("both_m10",   32'(ival_m10), 0);
    pulse_reset();
    tick(10);

    // Random traffic
    for (int r = 0; r < 150; r++) begin
      int k;
      k = $urandom_range(0, 19);
      if (k < 8)       press(0);
      else if (k < 12) press(1);
      else if (k < 14) press(2);
      else if (k < 16) begin glitch($urandom_range(1, 3)); tick(DEB + 3); end
      else if (k < 19) tick($urandom_range(10, 80));
      else             pulse_reset();
    end
    tick(40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
